// File: rtl/conv11_sched_if.sv
// Bus bundle between the 1x1 convolution sequencer and its surroundings.
//   master modport: the sequencer (conv11_sched)
//   slave  modport: environment (feature-map buffer, weight ROM, datapath,
//                   result buffer, run controller)
// Signals:
//   start/busy/done         run control
//   fm_addr/fm_rdata        feature-map buffer read (1-cycle read latency)
//   wt_addr/wt_rdata        weight ROM read, w1..w12 then bias (1-cycle latency)
//   conv_en/conv_in/conv_w  datapath drive
//   conv_value              datapath result (1 cycle after conv_en)
//   res_we/res_addr/res_data result buffer write
interface conv11_sched_if #(
    parameter int BIT_WIDTH = 8,
    parameter int OUT_WIDTH = 32,
    parameter int FM_AW     = 6,
    parameter int OC_AW     = 4,
    parameter int RES_AW    = 10
);
    logic                        start;
    logic                        busy;
    logic                        done;
    logic [FM_AW-1:0]            fm_addr;
    logic [12*BIT_WIDTH-1:0]     fm_rdata;
    logic [OC_AW-1:0]            wt_addr;
    logic [13*BIT_WIDTH-1:0]     wt_rdata;
    logic                        conv_en;
    logic [12*BIT_WIDTH-1:0]     conv_in;
    logic [13*BIT_WIDTH-1:0]     conv_w;
    logic signed [OUT_WIDTH-1:0] conv_value;
    logic                        res_we;
    logic [RES_AW-1:0]           res_addr;
    logic [BIT_WIDTH-1:0]        res_data;

    modport master (
        input  start, fm_rdata, wt_rdata, conv_value,
        output busy, done, fm_addr, wt_addr, conv_en, conv_in, conv_w,
               res_we, res_addr, res_data
    );

    modport slave (
        output start, fm_rdata, wt_rdata, conv_value,
        input  busy, done, fm_addr, wt_addr, conv_en, conv_in, conv_w,
               res_we, res_addr, res_data
    );
endinterface

// File: rtl/conv11_sched.sv
// Sequencer for the 12-channel 1x1 convolution datapath on a 6x6 map.
// For each output channel: fetch weights+bias, latch them onto conv_w, stream
// all MAP_SIZE pixels through the datapath one per cycle, requantize each
// 32-bit result (ReLU, arithmetic shift, saturate to 0..127) and write it to
// the result buffer at oc*MAP_SIZE + pixel.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         conv11_sched_if.master (run control, fm/wt reads,
//               datapath drive, result writes)
module conv11_sched #(
    parameter int BIT_WIDTH = 8,
    parameter int OUT_WIDTH = 32,
    parameter int MAP_SIZE  = 36,
    parameter int OUT_CH    = 16,
    parameter int SHIFT     = 7,
    parameter int FM_AW     = 6,
    parameter int OC_AW     = 4,
    parameter int RES_AW    = 10
) (
    input logic             clk,
    input logic             rst_n,
    conv11_sched_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LATCH_W, S_STREAM, S_DRAIN0, S_DRAIN1, S_FIN
    } state_t;

    localparam logic [FM_AW-1:0] P_LAST  = FM_AW'(MAP_SIZE - 1);
    localparam logic [OC_AW-1:0] OC_LAST = OC_AW'(OUT_CH - 1);
    localparam logic signed [OUT_WIDTH-1:0] SAT_MAX =
        OUT_WIDTH'((1 << (BIT_WIDTH - 1)) - 1);

    state_t                   state, state_nxt;
    logic [OC_AW-1:0]         oc;
    logic [FM_AW-1:0]         p;
    logic [13*BIT_WIDTH-1:0]  conv_w_q;

    logic busy_c, done_c, issue, latch_w;

    logic                     vld_p0, vld_p1;
    logic [OC_AW-1:0]         tag_oc_p0, tag_oc_p1;
    logic [FM_AW-1:0]         tag_p_p0, tag_p_p1;
    logic                     res_we_p2;
    logic [RES_AW-1:0]        res_addr_p2;
    logic [BIT_WIDTH-1:0]     res_data_p2;

    // ReLU, arithmetic shift, saturate to the positive activation range.
    function automatic logic [BIT_WIDTH-1:0] requant(
        input logic signed [OUT_WIDTH-1:0] v
    );
        logic signed [OUT_WIDTH-1:0] s;
        s = v >>> SHIFT;
        if (v[OUT_WIDTH-1])
            requant = '0;
        else if (s > SAT_MAX)
            requant = SAT_MAX[BIT_WIDTH-1:0];
        else
            requant = s[BIT_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (bus.start) state_nxt = S_LOAD_W;
            S_LOAD_W:  state_nxt = S_LATCH_W;
            S_LATCH_W: state_nxt = S_STREAM;
            S_STREAM:  if (p == P_LAST) state_nxt = S_DRAIN0;
            S_DRAIN0:  state_nxt = S_DRAIN1;
            S_DRAIN1:  state_nxt = (oc == OC_LAST) ? S_FIN : S_LOAD_W;
            S_FIN:     state_nxt = S_IDLE;   // start in this cycle is dropped
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_c  = 1'b0;
        done_c  = 1'b0;
        issue   = 1'b0;
        latch_w = 1'b0;
        case (state)
            S_LOAD_W:  busy_c = 1'b1;
            S_LATCH_W: begin busy_c = 1'b1; latch_w = 1'b1; end
            S_STREAM:  begin busy_c = 1'b1; issue = 1'b1; end
            S_DRAIN0:  busy_c = 1'b1;
            S_DRAIN1:  busy_c = 1'b1;
            S_FIN:     done_c = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oc <= '0;
            p  <= '0;
        end else begin
            if (state == S_FIN || (state == S_IDLE && bus.start))
                oc <= '0;
            else if (state == S_DRAIN1 && oc != OC_LAST)
                oc <= oc + OC_AW'(1);
            if (latch_w || state == S_FIN)
                p <= '0;
            else if (issue)
                p <= p + FM_AW'(1);
        end
    end

    // Weights stay on conv_w until the next LATCH_W, which only follows DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            conv_w_q <= '0;
        else if (latch_w)
            conv_w_q <= bus.wt_rdata;
    end

    // ---- stage p0: pixel read issued last cycle, datapath enabled now ----
    // ---- stage p1: datapath result valid on conv_value ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= issue;
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        tag_oc_p0 <= oc;
        tag_p_p0  <= p;
        tag_oc_p1 <= tag_oc_p0;
        tag_p_p1  <= tag_p_p0;
    end

    // ---- stage p2: registered result write ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_we_p2   <= 1'b0;
            res_addr_p2 <= '0;
            res_data_p2 <= '0;
        end else begin
            res_we_p2 <= vld_p1;
            if (vld_p1) begin
                res_addr_p2 <= RES_AW'(tag_oc_p1) * RES_AW'(MAP_SIZE)
                             + RES_AW'(tag_p_p1);
                res_data_p2 <= requant(bus.conv_value);
            end
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.fm_addr  = issue ? p : '0;
    assign bus.wt_addr  = oc;
    assign bus.conv_en  = vld_p0;
    // The buffer read is already registered, so the pixel lands in the same
    // cycle as conv_en; gating keeps conv_in at zero between pixels.
    assign bus.conv_in  = vld_p0 ? bus.fm_rdata : '0;
    assign bus.conv_w   = conv_w_q;
    assign bus.res_we   = res_we_p2;
    assign bus.res_addr = res_addr_p2;
    assign bus.res_data = res_data_p2;

endmodule

// File: tb/tb_conv11_sched.sv
// Bench for conv11_sched: two instances (SHIFT=7 and SHIFT=0) share one
// feature-map/weight memory image; each has its own buffer/ROM read model,
// behavioural MAC datapath and result-write log.
module tb_conv11_sched;
    localparam int BW      = 8;
    localparam int MS      = 36;
    localparam int OC      = 16;
    localparam int NW      = MS * OC;
    localparam int EXP_CYC = OC * 40 + 1;
    localparam int RUN_WIN = 700;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    conv11_sched_if #(.BIT_WIDTH(8), .OUT_WIDTH(32), .FM_AW(6), .OC_AW(4), .RES_AW(10)) bus_a ();
    conv11_sched_if #(.BIT_WIDTH(8), .OUT_WIDTH(32), .FM_AW(6), .OC_AW(4), .RES_AW(10)) bus_b ();

    conv11_sched #(.SHIFT(7)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    conv11_sched #(.SHIFT(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic signed [7:0] fm_mem [0:MS-1][0:11];
    logic signed [7:0] wt_mem [0:OC-1][0:12];   // [12] is bias

    logic [9:0] qa_addr[$], qb_addr[$];
    logic [7:0] qa_data[$], qb_data[$];

    function automatic logic [95:0] fm_word(input int a);
        logic [95:0] r;
        r = '0;
        if (a < MS)
            for (int c = 0; c < 12; c++) r[c*8 +: 8] = fm_mem[a][c];
        return r;
    endfunction

    function automatic logic [103:0] wt_word(input int a);
        logic [103:0] r;
        for (int c = 0; c < 13; c++) r[c*8 +: 8] = wt_mem[a][c];
        return r;
    endfunction

    function automatic logic signed [31:0] mac(input logic [95:0] x, input logic [103:0] w);
        int acc;
        acc = int'($signed(w[96 +: 8]));
        for (int c = 0; c < 12; c++)
            acc += int'($signed(x[c*8 +: 8])) * int'($signed(w[c*8 +: 8]));
        return acc;
    endfunction

    // Environment: registered buffer/ROM reads and a registered MAC.
    always @(posedge clk) begin
        bus_a.fm_rdata <= fm_word(int'(bus_a.fm_addr));
        bus_a.wt_rdata <= wt_word(int'(bus_a.wt_addr));
        if (bus_a.conv_en) bus_a.conv_value <= mac(bus_a.conv_in, bus_a.conv_w);
        bus_b.fm_rdata <= fm_word(int'(bus_b.fm_addr));
        bus_b.wt_rdata <= wt_word(int'(bus_b.wt_addr));
        if (bus_b.conv_en) bus_b.conv_value <= mac(bus_b.conv_in, bus_b.conv_w);
    end

    always @(negedge clk) begin
        if (bus_a.res_we === 1'b1) begin
            qa_addr.push_back(bus_a.res_addr);
            qa_data.push_back(bus_a.res_data);
        end
        if (bus_b.res_we === 1'b1) begin
            qb_addr.push_back(bus_b.res_addr);
            qb_data.push_back(bus_b.res_data);
        end
    end

    // Reference: dot product over the memory image, then ReLU/divide/clip.
    function automatic int exp_val(input int oc, input int p, input int sh);
        int v, q;
        v = int'(wt_mem[oc][12]);
        for (int c = 0; c < 12; c++) v += int'(fm_mem[p][c]) * int'(wt_mem[oc][c]);
        if (v < 0) return 0;
        q = v / (1 << sh);
        return (q > 127) ? 127 : q;
    endfunction

    task automatic fill(input int fmv, input int wv, input int bv);
        for (int p = 0; p < MS; p++)
            for (int c = 0; c < 12; c++) fm_mem[p][c] = 8'(fmv);
        for (int o = 0; o < OC; o++) begin
            for (int c = 0; c < 12; c++) wt_mem[o][c] = 8'(wv);
            wt_mem[o][12] = 8'(bv);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) bus_a.start = v;
        else          bus_b.start = v;
    endtask

    // Runs one start, optionally re-pulsing start at cycle extra_at, over a
    // fixed window. Cycle 1 is the clock edge that samples start.
    task automatic run(input int sel, input int extra_at,
                       output int cycles, output int ndone, output int busy_bad);
        int cnt;
        logic dn, bz;
        qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
        cycles = -1; ndone = 0; busy_bad = 0;
        set_start(sel, 1'b1);
        cnt = 0;
        while (cnt < RUN_WIN) begin
            @(posedge clk); #1; cnt++;
            set_start(sel, cnt == extra_at);
            dn = (sel == 0) ? bus_a.done : bus_b.done;
            bz = (sel == 0) ? bus_a.busy : bus_b.busy;
            if (dn === 1'b1) begin
                ndone++;
                if (cycles < 0) cycles = cnt;
            end
            if (bz !== (cnt < EXP_CYC)) busy_bad++;
        end
        set_start(sel, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        fill(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus_a.busy, bus_a.done, bus_a.conv_en, bus_a.res_we, bus_a.fm_addr, bus_a.wt_addr,
             bus_a.res_addr, bus_a.res_data, bus_a.conv_in, bus_a.conv_w} !== '0) begin
            errors++; $display("FAIL reset_outputs_a got busy=%b res_we=%b conv_w=%h want all zero",
                               bus_a.busy, bus_a.res_we, bus_a.conv_w);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus_a.busy, bus_a.done, bus_a.conv_en, bus_a.res_we, bus_a.fm_addr, bus_a.wt_addr,
                 bus_a.res_addr, bus_a.res_data, bus_a.conv_in, bus_a.conv_w,
                 bus_b.busy, bus_b.done, bus_b.res_we, bus_b.res_addr} !== '0) begin
                errors++; $display("FAIL idle_outputs cycle %0d got busy=%b/%b res_we=%b/%b want all zero",
                                   i, bus_a.busy, bus_b.busy, bus_a.res_we, bus_b.res_we);
            end
        end
    endtask

    task automatic test_ones;
        int cyc, nd, bb;
        fill(1, 1, 0);
        run(0, 0, cyc, nd, bb);
        checks++;
        if (cyc !== EXP_CYC) begin errors++; $display("FAIL ones_done_cycle got %0d want %0d", cyc, EXP_CYC); end
        checks++;
        if (nd !== 1 || bb !== 0) begin errors++; $display("FAIL ones_done_busy got done=%0d busy_err=%0d want 1 0", nd, bb); end
        checks++;
        if (qa_addr.size() !== NW) begin errors++; $display("FAIL ones_write_count got %0d want %0d", qa_addr.size(), NW); end
        for (int k = 0; k < qa_addr.size() && k < NW; k++) begin
            checks++;
            if (qa_addr[k] !== 10'(k) || qa_data[k] !== 8'(exp_val(k / MS, k % MS, 7))) begin
                errors++; $display("FAIL ones_write %0d got addr=%0d data=%0d want addr=%0d data=%0d",
                                   k, qa_addr[k], qa_data[k], k, exp_val(k / MS, k % MS, 7));
            end
        end
    endtask

    task automatic test_shift0;
        int cyc, nd, bb;
        int fmv[3] = '{10, 11, 10};
        int wv[3]  = '{1, 1, -1};
        int want[3] = '{125, 127, 0};
        for (int t = 0; t < 3; t++) begin
            fill(fmv[t], wv[t], 5);
            run(1, 0, cyc, nd, bb);
            checks++;
            if (cyc !== EXP_CYC || nd !== 1) begin
                errors++; $display("FAIL shift0_run%0d got cycle=%0d done=%0d want %0d 1", t, cyc, nd, EXP_CYC);
            end
            checks++;
            if (qb_addr.size() !== NW) begin errors++; $display("FAIL shift0_count%0d got %0d want %0d", t, qb_addr.size(), NW); end
            for (int k = 0; k < qb_addr.size() && k < NW; k++) begin
                checks++;
                if (qb_addr[k] !== 10'(k) || qb_data[k] !== 8'(want[t])) begin
                    errors++; $display("FAIL shift0_write%0d_%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                                       t, k, qb_addr[k], qb_data[k], k, want[t]);
                end
            end
        end
    endtask

    task automatic test_changeover;
        int cyc, nd, bb;
        fill(64, 0, 0);
        for (int o = 0; o < OC; o++)
            for (int c = 0; c < 12; c++) wt_mem[o][c] = 8'(o + 1);
        run(0, 0, cyc, nd, bb);
        checks++;
        if (qa_addr.size() !== NW) begin errors++; $display("FAIL chg_count got %0d want %0d", qa_addr.size(), NW); end
        if (qa_addr.size() > 36) begin
            checks++;
            if (qa_addr[35] !== 10'd35 || qa_data[35] !== 8'd6) begin
                errors++; $display("FAIL chg_last_oc0 got addr=%0d data=%0d want 35 6", qa_addr[35], qa_data[35]);
            end
            checks++;
            if (qa_addr[36] !== 10'd36 || qa_data[36] !== 8'd12) begin
                errors++; $display("FAIL chg_first_oc1 got addr=%0d data=%0d want 36 12", qa_addr[36], qa_data[36]);
            end
        end
        for (int k = 0; k < qa_addr.size() && k < NW; k++) begin
            checks++;
            if (qa_addr[k] !== 10'(k) || qa_data[k] !== 8'(exp_val(k / MS, k % MS, 7))) begin
                errors++; $display("FAIL chg_write %0d got addr=%0d data=%0d want addr=%0d data=%0d",
                                   k, qa_addr[k], qa_data[k], k, exp_val(k / MS, k % MS, 7));
            end
        end
    endtask

    task automatic test_random;
        int cyc, nd, bb;
        for (int p = 0; p < MS; p++)
            for (int c = 0; c < 12; c++) fm_mem[p][c] = 8'($urandom_range(0, 255));
        for (int o = 0; o < OC; o++)
            for (int c = 0; c < 13; c++) wt_mem[o][c] = 8'($urandom_range(0, 255));
        run(0, 0, cyc, nd, bb);
        checks++;
        if (qa_addr.size() !== NW || cyc !== EXP_CYC) begin
            errors++; $display("FAIL rand_a_run got writes=%0d cycle=%0d want %0d %0d", qa_addr.size(), cyc, NW, EXP_CYC);
        end
        for (int k = 0; k < qa_addr.size() && k < NW; k++) begin
            checks++;
            if (qa_addr[k] !== 10'(k) || qa_data[k] !== 8'(exp_val(k / MS, k % MS, 7))) begin
                errors++; $display("FAIL rand_a_write %0d got addr=%0d data=%0d want addr=%0d data=%0d",
                                   k, qa_addr[k], qa_data[k], k, exp_val(k / MS, k % MS, 7));
            end
        end
        // Small magnitudes so the unshifted instance sees a mix of zero,
        // in-range and saturated results.
        for (int p = 0; p < MS; p++)
            for (int c = 0; c < 12; c++) fm_mem[p][c] = 8'($urandom_range(0, 7));
        for (int o = 0; o < OC; o++)
            for (int c = 0; c < 13; c++) wt_mem[o][c] = 8'(int'($urandom_range(0, 6)) - 3);
        run(1, 0, cyc, nd, bb);
        checks++;
        if (qb_addr.size() !== NW || cyc !== EXP_CYC) begin
            errors++; $display("FAIL rand_b_run got writes=%0d cycle=%0d want %0d %0d", qb_addr.size(), cyc, NW, EXP_CYC);
        end
        for (int k = 0; k < qb_addr.size() && k < NW; k++) begin
            checks++;
            if (qb_addr[k] !== 10'(k) || qb_data[k] !== 8'(exp_val(k / MS, k % MS, 0))) begin
                errors++; $display("FAIL rand_b_write %0d got addr=%0d data=%0d want addr=%0d data=%0d",
                                   k, qb_addr[k], qb_data[k], k, exp_val(k / MS, k % MS, 0));
            end
        end
    endtask

    task automatic test_restart_ignored;
        int cyc, nd, bb;
        int at[2] = '{100, EXP_CYC};   // mid-run, and in the done cycle
        for (int t = 0; t < 2; t++) begin
            run(0, at[t], cyc, nd, bb);
            checks++;
            if (cyc !== EXP_CYC || nd !== 1) begin
                errors++; $display("FAIL restart%0d_done got cycle=%0d count=%0d want %0d 1", t, cyc, nd, EXP_CYC);
            end
            checks++;
            if (bb !== 0 || bus_a.busy !== 1'b0) begin
                errors++; $display("FAIL restart%0d_busy got errs=%0d busy=%b want 0 0", t, bb, bus_a.busy);
            end
            checks++;
            if (qa_addr.size() !== NW) begin
                errors++; $display("FAIL restart%0d_count got %0d want %0d", t, qa_addr.size(), NW);
            end
        end
    endtask

    task automatic test_reset_midrun;
        int cnt, n_before, cyc, nd, bb;
        qa_addr.delete(); qa_data.delete();
        bus_a.start = 1'b1;
        cnt = 0;
        while (cnt < 200) begin
            @(posedge clk); #1; cnt++;
            bus_a.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_before = qa_addr.size();
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.res_we !== 1'b0 || bus_a.conv_en !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got busy=%b res_we=%b conv_en=%b want 0 0 0",
                               bus_a.busy, bus_a.res_we, bus_a.conv_en);
        end
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (qa_addr.size() !== n_before) begin
            errors++; $display("FAIL midrst_writes got %0d want %0d", qa_addr.size(), n_before);
        end
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
            errors++; $display("FAIL midrst_idle got busy=%b done=%b want 0 0", bus_a.busy, bus_a.done);
        end
        run(0, 0, cyc, nd, bb);
        checks++;
        if (cyc !== EXP_CYC || nd !== 1 || bb !== 0) begin
            errors++; $display("FAIL midrst_rerun got cycle=%0d done=%0d busy_err=%0d want %0d 1 0", cyc, nd, bb, EXP_CYC);
        end
        checks++;
        if (qa_addr.size() !== NW) begin errors++; $display("FAIL midrst_count got %0d want %0d", qa_addr.size(), NW); end
        for (int k = 0; k < qa_addr.size() && k < NW; k++) begin
            checks++;
            if (qa_addr[k] !== 10'(k) || qa_data[k] !== 8'(exp_val(k / MS, k % MS, 7))) begin
                errors++; $display("FAIL midrst_write %0d got addr=%0d data=%0d want addr=%0d data=%0d",
                                   k, qa_addr[k], qa_data[k], k, exp_val(k / MS, k % MS, 7));
            end
        end
    endtask

    initial begin
        test_reset;
        test_ones;
        test_shift0;
        test_changeover;
        test_random;
        test_restart_ignored;
        test_reset_midrun;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
